// File: rtl/tetris_pkg.sv
// Shared definitions for the move handshake between the move request
// controller and the game-logic FSM.
//   - mrc_state_e : request controller states
//   - KEY_*       : KEY bus bit positions (KEY is active-low)
//   - MOVE_*      : one-hot move codes, ordered {Drop, Left, Right, Down}
//   - grant_pick  : fixed-priority pick, Drop > Left > Right > Down
package tetris_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_DROP_RPT = 2'd3
  } mrc_state_e;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_DROP  = 3;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 0;

  // Code bit positions equal the key indices, so a grant vector doubles as
  // the mask of the pend bit it retires.
  localparam logic [3:0] MOVE_NONE  = 4'b0000;
  localparam logic [3:0] MOVE_DROP  = 4'b1000;
  localparam logic [3:0] MOVE_LEFT  = 4'b0100;
  localparam logic [3:0] MOVE_RIGHT = 4'b0010;
  localparam logic [3:0] MOVE_DOWN  = 4'b0001;

  // Same decode order as the game-logic FSM.
  function automatic logic [3:0] grant_pick(input logic [3:0] pend);
    logic [3:0] g;
    g = MOVE_NONE;
    if (pend[KEY_DROP])       g = MOVE_DROP;
    else if (pend[KEY_LEFT])  g = MOVE_LEFT;
    else if (pend[KEY_RIGHT]) g = MOVE_RIGHT;
    else if (pend[KEY_DOWN])  g = MOVE_DOWN;
    return g;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// One push-button lane: 2-flop synchroniser plus falling-edge detector.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset (all flops reset to released = 1)
//   key_n_i : raw asynchronous active-low key
//   fall_o  : one-cycle pulse when the synchronised level goes 1 -> 0
module key_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= key_n_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // prev_q only holds edge history; s2_q is the synchronised level.
  assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/move_request_ctrl.sv
// Initiator side of the game-logic move handshake.
// Synchronises the four keys, runs the gravity timer, holds sticky pending
// requests and issues them one at a time as a one-hot move plus checkBoard.
//   CLOCK_50   : clock
//   Resetn     : asynchronous active-low reset
//   KEY[3:0]   : raw active-low keys, [3]=Drop [2]=Left [1]=Right [0]=Down
//   Enable     : game running; gates new transactions and the gravity timer
//   canDown    : piece can fall further; decides whether a Drop repeats
//   doneLogic  : game-logic FSM applied the move, held until checkBoard falls
//   checkBoard : request strobe, high for the whole transaction
//   DropBlock/LeftBlock/RightBlock/DownBlock : one-hot move while checkBoard
//   busy       : high from ISSUE entry until RELEASE exit
module move_request_ctrl
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = 25000000,
  parameter int CNT_W         = 25
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [3:0] KEY,
  input  logic       Enable,
  input  logic       canDown,
  input  logic       doneLogic,
  output logic       checkBoard,
  output logic       DropBlock,
  output logic       LeftBlock,
  output logic       RightBlock,
  output logic       DownBlock,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_TICKS - 1);

  logic [NUM_KEYS-1:0] key_fall;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_edge_sync u_sync (
      .clk_i   (CLOCK_50),
      .rst_n_i (Resetn),
      .key_n_i (KEY[gi]),
      .fall_o  (key_fall[gi])
    );
  end

  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mrc_state_e          state_q;
  logic [3:0]          move_q;
  logic                cb_q, busy_q, last_drop_q;

  logic       grant_en, wrap, down_grant;
  logic [3:0] grant;

  always_comb begin
    grant_en   = (state_q == ST_IDLE) && Enable && (pend_q != '0);
    grant      = grant_en ? grant_pick(pend_q) : MOVE_NONE;
    down_grant = grant[KEY_DOWN];
    wrap       = Enable && (cnt_q == CNT_LAST);
  end

  // Key edges are OR-ed in after the grant clear so a fresh press of the
  // granted key survives. A wrap coinciding with a Down grant is dropped:
  // that grant already serves it.
  always_comb begin
    pend_d = pend_q;
    if (!Enable) begin
      pend_d = '0;
    end else begin
      pend_d = (pend_q & ~grant) | key_fall;
      if (wrap && !down_grant) pend_d[KEY_DOWN] = 1'b1;
    end
  end

  // Any Down grant restarts the gravity period, so a key Down also
  // postpones the next gravity step.
  always_comb begin
    cnt_d = cnt_q;
    if (down_grant || wrap) cnt_d = '0;
    else if (Enable)        cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      move_q      <= MOVE_NONE;
      cb_q        <= 1'b0;
      busy_q      <= 1'b0;
      last_drop_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_en) begin
            state_q     <= ST_ISSUE;
            move_q      <= grant;
            cb_q        <= 1'b1;
            busy_q      <= 1'b1;
            last_drop_q <= grant[KEY_DROP];
          end
        end
        ST_ISSUE: begin
          if (doneLogic) begin
            state_q <= ST_RELEASE;
            move_q  <= MOVE_NONE;
            cb_q    <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // Wait for the logic FSM to drop doneLogic before anything new.
          if (!doneLogic) begin
            busy_q  <= 1'b0;
            state_q <= (last_drop_q && canDown) ? ST_DROP_RPT : ST_IDLE;
          end
        end
        ST_DROP_RPT: begin
          if (Enable) begin
            state_q <= ST_ISSUE;
            move_q  <= MOVE_DROP;
            cb_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign checkBoard = cb_q;
  assign busy       = busy_q;
  assign {DropBlock, LeftBlock, RightBlock, DownBlock} = move_q;

endmodule
